rfile_mp: RTL
=============

# rfile_mp

Parametrised multi-read-port register file for the RISC-V core, the successor of the single-write/two-read integer register file. It provides NRP independently enabled registered read ports, one write port, and a per-register busy scoreboard for hazard detection by the decode stage. It sits between decode (reads and reservations) and writeback (writes), with an optional same-cycle write-to-read bypass.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2; AW = $clog2(DEPTH).
- NRP, 2, number of read ports (1..4).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  NRP  per-port read enable.
- rs_addr  in  NRP*AW  read addresses; port p occupies [p*AW +: AW].
- rs_data  out  NRP*XLEN  registered read data; port p occupies [p*XLEN +: XLEN].
- rs_valid  out  NRP  per-port 1-cycle pulse, high the cycle after rd_en[p].
- rs_busy  out  NRP  registered scoreboard bit of the register addressed at issue.
- rd_write  in  1  write enable.
- rd_addr  in  AW  write address.
- rd_data  in  XLEN  write data, signed two's complement.
- write_done  out  1  1-cycle pulse, high the cycle after any accepted write.
- reserve  in  1  mark register reserve_addr busy (outstanding producer).
- reserve_addr  in  AW  register to reserve.

## Operation
- Storage: DEPTH × XLEN array. Register 0 is hardwired zero: writes to it are discarded, it reads 0, and it is never busy.
- Read port p: when rd_en[p]=1, on the edge rs_data[p] ← reg[rs_addr[p]], rs_busy[p] ← busy[rs_addr[p]] and rs_valid[p] ← 1. When rd_en[p]=0, rs_data[p] and rs_busy[p] hold their values and rs_valid[p] ← 0.
- Write: when rd_write=1, reg[rd_addr] ← rd_data and busy[rd_addr] ← 0. write_done ← 1 on every cycle with rd_write=1, including writes to register 0. Otherwise write_done ← 0.
- Scoreboard: when reserve=1 and reserve_addr≠0, busy[reserve_addr] ← 1.
- Simultaneous reserve and write to the same address: reserve wins, so busy stays 1 (a new producer supersedes the completing one). Data is still written.
- Multiple read ports may address the same register; each port returns the same value.
- Reset: all registers, all busy bits, rs_data, rs_busy, rs_valid and write_done clear to 0 on the edge where reset=1. Reset overrides every concurrent read, write and reserve. An operation issued in the reset cycle is lost; its valid or done pulse does not appear.

## Timing
- Read latency: 1 cycle from rd_en to rs_data/rs_valid. Ports are fully pipelined, one read per port per cycle.
- Write latency: data is visible to reads issued in the cycle after rd_write. write_done follows rd_write by 1 cycle.
- Read and write of the same address in the same cycle are resolved per the Configuration section.
- rs_busy reflects busy state before same-cycle reserve or write updates. A same-cycle write to that address, with bypass enabled, reports busy 0.
- There is no back-pressure; all inputs are accepted every cycle.

## Configuration
- RFILE_BYPASS_EN defined: a read issued in the same cycle as a write to the same nonzero address returns rd_data (write-first), and rs_busy for that port reports 0 unless a same-cycle reserve hits that address.
- RFILE_BYPASS_EN undefined: the same-cycle read returns the old register contents and the old busy bit (read-first). Decode must stall one cycle.

## Test plan
- Reset: write 0x1234 to r5, assert reset for 1 cycle, then read r5 on port 0 → rs_data 0, rs_valid 1, rs_busy 0, write_done 0 in the cycle after reset.
- Zero register: write 0xDEADBEEF to r0 → write_done pulses 1 cycle later; a later read of r0 on all ports → 0. Reserve r0 → rs_busy stays 0.
- Multi-port read: write r3=3 and r7=-7, then in one cycle read port0=r3 and port1=r7 → 0x00000003 and 0xFFFFFFF9 next cycle. Deassert rd_en → values hold and rs_valid=0.
- Bypass: in the same cycle write r9=0x55 and read r9 (old value 0x11) → 0x55 with RFILE_BYPASS_EN, 0x11 without it.
- Scoreboard: reserve r4, read r4 → busy 1. Write r4=8, read next cycle → busy 0 and data 8. Reserve and write r4 in the same cycle → busy 1.
- Reset mid-operation: issue read r3 and write r3=9 in the same cycle with reset=1 → next cycle all outputs are 0 and r3 reads 0 afterwards.

Source files
------------

// File: rtl/rfile_mp_if.sv
// Bus bundle for rfile_mp: read ports, write port and scoreboard reservation.
// The decode/writeback side uses the master modport, the register file uses slave.
interface rfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
);
  logic [NRP-1:0]      rd_en;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_valid;
  logic [NRP-1:0]      rs_busy;
  logic                rd_write;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic                write_done;
  logic                reserve;
  logic [AW-1:0]       reserve_addr;

  modport master (
    output rd_en, rs_addr, rd_write, rd_addr, rd_data, reserve, reserve_addr,
    input  rs_data, rs_valid, rs_busy, write_done
  );

  modport slave (
    input  rd_en, rs_addr, rd_write, rd_addr, rd_data, reserve, reserve_addr,
    output rs_data, rs_valid, rs_busy, write_done
  );
endinterface

// File: rtl/rfile_mp.sv
// Multi-read-port register file with busy scoreboard; r0 is hardwired zero.
// Define RFILE_BYPASS_EN for write-first same-cycle read/write; default is read-first.
module rfile_mp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int NRP   = 2
) (
  input logic       clk,
  input logic       reset,
  rfile_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0]      regs_r [DEPTH];
  logic [DEPTH-1:0]     busy_r;
  logic [DEPTH-1:0]     busy_nxt_s;
  logic [AW-1:0]        addr_s [NRP];
  logic [XLEN-1:0]      rd_val_s [NRP];
  logic [NRP-1:0]       rd_busy_s;
  logic [NRP-1:0]       bypass_s;
  logic                 wr_hit_s;
  logic [NRP*XLEN-1:0]  rs_data_r;
  logic [NRP-1:0]       rs_valid_r;
  logic [NRP-1:0]       rs_busy_r;
  logic                 write_done_r;

  assign wr_hit_s = bus.rd_write && (bus.rd_addr != {AW{1'b0}});

  // Scoreboard next state: a write clears, a same-cycle reserve wins over it.
  always_comb begin
    busy_nxt_s = busy_r;
    if (bus.rd_write) begin
      busy_nxt_s[bus.rd_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (bus.reserve && (bus.reserve_addr != {AW{1'b0}})) begin
      busy_nxt_s[bus.reserve_addr] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Per-port read value and busy bit, including the optional write-first bypass.
  always_comb begin
    for (int p = 0; p < NRP; p++) begin
      addr_s[p] = bus.rs_addr[p*AW +: AW];
`ifdef RFILE_BYPASS_EN
      bypass_s[p] = wr_hit_s && (bus.rd_addr == addr_s[p]);
`else
      bypass_s[p] = 1'b0;
`endif
      if (bypass_s[p]) begin
        rd_val_s[p]  = bus.rd_data;
        rd_busy_s[p] = bus.reserve && (bus.reserve_addr == addr_s[p]);
      end else if (addr_s[p] == {AW{1'b0}}) begin
        rd_val_s[p]  = {XLEN{1'b0}};
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_val_s[p]  = regs_r[addr_s[p]];
        rd_busy_s[p] = busy_r[addr_s[p]];
      end
    end
  end

  // Storage, scoreboard and registered port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
      busy_r       <= {DEPTH{1'b0}};
      rs_data_r    <= {(NRP*XLEN){1'b0}};
      rs_valid_r   <= {NRP{1'b0}};
      rs_busy_r    <= {NRP{1'b0}};
      write_done_r <= 1'b0;
    end else begin
      if (wr_hit_s) begin
        regs_r[bus.rd_addr] <= bus.rd_data;
      end
      busy_r       <= busy_nxt_s;
      write_done_r <= bus.rd_write;
      for (int p = 0; p < NRP; p++) begin
        rs_valid_r[p] <= bus.rd_en[p];
        if (bus.rd_en[p]) begin
          rs_data_r[p*XLEN +: XLEN] <= rd_val_s[p];
          rs_busy_r[p]              <= rd_busy_s[p];
        end
      end
    end
  end

  assign bus.rs_data    = rs_data_r;
  assign bus.rs_valid   = rs_valid_r;
  assign bus.rs_busy    = rs_busy_r;
  assign bus.write_done = write_done_r;
endmodule
